// File: rtl/cr_cddip_supportPKG.sv
// Shared types and sizes for the CDDIP support block.
// Holds the admission FSM state encoding and the default in-flight counter width.
package cr_cddip_supportPKG;

    localparam int CR_SUP_ADMIT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2,
        HALT     = 2'd3
    } adm_state_e;

endpackage

// File: rtl/cr_cddip_sup_updn_cnt.sv
// Saturating up/down counter with an underflow indication.
// Simultaneous inc and dec cancel; a dec at zero holds the count and raises underflow.
module cr_cddip_sup_updn_cnt
    import cr_cddip_supportPKG::*;
#(
    parameter int W = CR_SUP_ADMIT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         underflow
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    assign underflow = dec & ~inc & (cnt == '0);

    // NOTE: async reset in the sensitivity list; state is only ever updated with <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/cr_cddip_sup_admit_ctl.sv
// RQE admission controller: in-flight throttling, drain/quiesce handshake and halt on interrupt.
// Optional drain watchdog enabled by defining CR_CDDIP_SUP_ADMIT_WDOG_EN.
module cr_cddip_sup_admit_ctl
    import cr_cddip_supportPKG::*;
#(
    parameter int                CNT_W      = CR_SUP_ADMIT_CNT_W,
    parameter int                WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_max_inflight,
    input  logic             cfg_drain_req,
    input  logic             rqe_vld,
    output logic             rqe_rdy,
    output logic             sup_rqe_admit,
    input  logic             osf_sup_cqe_exit,
    input  logic             pre_cddip_int,
    input  logic             err_clr,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic [1:0]       adm_state,
    output logic             drain_done,
    output logic             underflow_err,
    output logic             drain_timeout
);

    adm_state_e state_q;
    logic       cnt_underflow;

    assign adm_state     = state_q;
    assign drain_done    = (state_q == QUIESCED);
    assign rqe_rdy       = (state_q == RUN) && (inflight_cnt < cfg_max_inflight);
    assign sup_rqe_admit = rqe_vld & rqe_rdy;

    cr_cddip_sup_updn_cnt #(
        .W (CNT_W)
    ) u_inflight_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (sup_rqe_admit),
        .dec       (osf_sup_cqe_exit),
        .cnt       (inflight_cnt),
        .underflow (cnt_underflow)
    );

`ifdef CR_CDDIP_SUP_ADMIT_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_expire;

    // Fires on the edge that completes WDOG_LIMIT cycles in DRAIN; an empty pipe wins.
    assign wdog_expire = (state_q == DRAIN) && !pre_cddip_int &&
                         (inflight_cnt != '0) && (wdog_cnt == WDOG_LIMIT - WDOG_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt      <= '0;
            drain_timeout <= 1'b0;
        end else begin
            if (state_q == DRAIN) begin
                wdog_cnt <= wdog_cnt + WDOG_ONE;
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_expire) begin
                drain_timeout <= 1'b1;
            end else if (err_clr) begin
                drain_timeout <= 1'b0;
            end
        end
    end
`else
    logic [WDOG_W-1:0] unused_wdog_limit;

    assign unused_wdog_limit = WDOG_LIMIT;
    assign drain_timeout     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            underflow_err <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (pre_cddip_int) begin
                        state_q <= HALT;
                    end else if (cfg_drain_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pre_cddip_int) begin
                        state_q <= HALT;
                    end else if (inflight_cnt == '0) begin
                        state_q <= QUIESCED;
`ifdef CR_CDDIP_SUP_ADMIT_WDOG_EN
                    end else if (wdog_expire) begin
                        state_q <= HALT;
`endif
                    end
                end
                QUIESCED: begin
                    if (pre_cddip_int) begin
                        state_q <= HALT;
                    end else if (!cfg_drain_req) begin
                        state_q <= RUN;
                    end
                end
                HALT: begin
                    // Recovery always passes through DRAIN so the pipe is empty before RUN.
                    if (err_clr && !pre_cddip_int) begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= RUN;
            endcase

            if (cnt_underflow) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end

endmodule
